// File: rtl/video_pkg.sv
// Shared types and constants for the video pattern transmitter.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    RAMP    = 2'd1,
    CHECKER = 2'd2,
    STAMP   = 2'd3
  } pattern_t;

  // Colour bar table, left to right, {red, green, blue}.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Total period of one axis: active + front porch + sync + back porch.
  function automatic int unsigned total_len(input int unsigned act,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with registered dv/hsync/vsync decode.
// adv loads the next raster position (pixel (0,0) when not yet running);
// clr returns to the idle rest state.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned HRES   = 1600,
  parameter int unsigned VRES   = 900,
  parameter int unsigned H_FP   = 24,
  parameter int unsigned H_SYNC = 80,
  parameter int unsigned H_BP   = 96,
  parameter int unsigned V_FP   = 1,
  parameter int unsigned V_SYNC = 3,
  parameter int unsigned V_BP   = 96,
  parameter logic        HS_POL = 1'b1,
  parameter logic        VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        adv,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        dv,
  output logic        hs,
  output logic        vs,
  output logic [10:0] nxt_h,
  output logic [7:0]  nxt_v_lo,
  output logic        nxt_dv,
  output logic        last
);

  localparam int unsigned HTOT = total_len(HRES, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTOT = total_len(VRES, V_FP, V_SYNC, V_BP);

  logic        live;
  logic [10:0] nxt_v;
  logic        nxt_hs_act;
  logic        nxt_vs_act;

  // Next raster position and its decode; a non-running generator starts at (0,0).
  always_comb begin
    nxt_h = '0;
    nxt_v = '0;
    if (live) begin
      if (h_cnt == 11'(HTOT - 1)) begin
        nxt_h = '0;
        nxt_v = (v_cnt == 11'(VTOT - 1)) ? '0 : v_cnt + 11'd1;
      end else begin
        nxt_h = h_cnt + 11'd1;
        nxt_v = v_cnt;
      end
    end
    nxt_dv     = (nxt_h < 11'(HRES)) && (nxt_v < 11'(VRES));
    nxt_hs_act = (nxt_h >= 11'(HRES + H_FP)) && (nxt_h < 11'(HRES + H_FP + H_SYNC));
    nxt_vs_act = (nxt_v >= 11'(VRES + V_FP)) && (nxt_v < 11'(VRES + V_FP + V_SYNC));
  end

  assign nxt_v_lo = nxt_v[7:0];
  assign last     = live && (h_cnt == 11'(HTOT - 1)) && (v_cnt == 11'(VTOT - 1));

  // Counter and sync/dv registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      live  <= 1'b0;
      dv    <= 1'b0;
      hs    <= ~HS_POL;
      vs    <= ~VS_POL;
    end else if (clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
      live  <= 1'b0;
      dv    <= 1'b0;
      hs    <= ~HS_POL;
      vs    <= ~VS_POL;
    end else if (adv) begin
      h_cnt <= nxt_h;
      v_cnt <= nxt_v;
      live  <= 1'b1;
      dv    <= nxt_dv;
      hs    <= nxt_hs_act ? HS_POL : ~HS_POL;
      vs    <= nxt_vs_act ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: rtl/video_pattern_tx.sv
// Video test-pattern transmitter: run/drain FSM, pattern generation and
// registered pixel outputs aligned with the timing generator.
module video_pattern_tx
  import video_pkg::*;
#(
  parameter int unsigned HRES   = 1600,
  parameter int unsigned VRES   = 900,
  parameter int unsigned H_FP   = 24,
  parameter int unsigned H_SYNC = 80,
  parameter int unsigned H_BP   = 96,
  parameter int unsigned V_FP   = 1,
  parameter int unsigned V_SYNC = 3,
  parameter int unsigned V_BP   = 96,
  parameter logic        HS_POL = 1'b1,
  parameter logic        VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        vga_dv_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  state_t      state;
  state_t      state_nxt;
  pattern_t    pat_q;
  pattern_t    pat_use;
  logic        tg_clr;
  logic        tg_adv;
  logic        tg_last;
  logic [10:0] nxt_h;
  logic [7:0]  nxt_v_lo;
  logic        nxt_dv;
  logic        start;
  logic        frame_done;
  logic [15:0] fcnt_nxt;
  logic [2:0]  bar_idx;
  logic [23:0] rgb_nxt;

  video_timing_gen #(
    .HRES   (HRES),
    .VRES   (VRES),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .HS_POL (HS_POL),
    .VS_POL (VS_POL)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .clr      (tg_clr),
    .adv      (tg_adv),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .dv       (vga_dv_o),
    .hs       (vga_hs_o),
    .vs       (vga_vs_o),
    .nxt_h    (nxt_h),
    .nxt_v_lo (nxt_v_lo),
    .nxt_dv   (nxt_dv),
    .last     (tg_last)
  );

  // Run/drain control: frames only end at the last raster pixel, so en never cuts a frame short.
  always_comb begin
    state_nxt  = state;
    tg_clr     = 1'b0;
    tg_adv     = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          tg_adv    = 1'b1;
          start     = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (tg_last) begin
          frame_done = 1'b1;
          if (en) begin
            state_nxt = RUN;
            tg_adv    = 1'b1;
            start     = 1'b1;
          end else begin
            state_nxt = IDLE;
            tg_clr    = 1'b1;
          end
        end else begin
          tg_adv    = 1'b1;
          state_nxt = en ? RUN : DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
        tg_clr    = 1'b1;
      end
    endcase
  end

  // Pixel colour for the position about to be presented.
  always_comb begin
    pat_use  = start ? pattern_t'(pattern_sel) : pat_q;
    fcnt_nxt = frame_cnt + {15'd0, frame_done};
    bar_idx  = 3'(nxt_h / 11'(HRES / 8));
    rgb_nxt  = '0;
    if (tg_adv && nxt_dv) begin
      case (pat_use)
        BARS:    rgb_nxt = BAR_RGB[bar_idx];
        RAMP:    rgb_nxt = {3{nxt_h[7:0]}};
        CHECKER: rgb_nxt = (nxt_h[5] ^ nxt_v_lo[5]) ? '1 : '0;
        STAMP:   rgb_nxt = {fcnt_nxt[7:0], nxt_h[7:0], nxt_v_lo[7:0]};
        default: rgb_nxt = '0;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Pattern latch, frame counter and registered pixel/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q       <= BARS;
      frame_cnt   <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (start) pat_q <= pat_use;
      frame_cnt          <= fcnt_nxt;
      {red, green, blue} <= rgb_nxt;
      frame_start        <= start;
      busy               <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_video_pattern_tx.sv
// Self-checking bench for video_pattern_tx with a small raster geometry.
module tb_video_pattern_tx;

  localparam int HRES = 16, VRES = 4;
  localparam int H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int HTOT = 24, VTOT = 8, FRAME = HTOT * VTOT;

  localparam logic [23:0] BAR_TB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pattern_sel;
  logic [10:0] h_cnt, v_cnt;
  logic        vga_dv_o, vga_hs_o, vga_vs_o;
  logic [7:0]  red, green, blue;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;

  video_pattern_tx #(
    .HRES(HRES), .VRES(VRES),
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .vga_dv_o(vga_dv_o), .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [66:0] obs;
  assign obs = {h_cnt, v_cnt, vga_dv_o, vga_hs_o, vga_vs_o, red, green, blue,
                frame_start, frame_cnt, busy};

  // Reference model: a linear position within the frame plus a running flag.
  logic        m_run;
  int          m_pos;
  logic [15:0] m_frames;
  logic [1:0]  m_pat;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 1'b0; m_pos <= 0; m_frames <= '0; m_pat <= '0;
    end else if (!m_run) begin
      if (en) begin m_run <= 1'b1; m_pos <= 0; m_pat <= pattern_sel; end
    end else if (m_pos == FRAME - 1) begin
      m_frames <= m_frames + 16'd1;
      if (en) begin m_pos <= 0; m_pat <= pattern_sel; end
      else m_run <= 1'b0;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  function automatic logic [66:0] exp_vec();
    int h, v;
    logic dv, hs, vs;
    logic [23:0] c;
    if (!m_run) return {22'd0, 3'b000, 24'd0, 1'b0, m_frames, 1'b0};
    h  = m_pos % HTOT;
    v  = m_pos / HTOT;
    dv = (h < HRES) && (v < VRES);
    hs = (h >= HRES + H_FP) && (h < HRES + H_FP + H_SYNC);
    vs = (v >= VRES + V_FP) && (v < VRES + V_FP + V_SYNC);
    c  = 24'd0;
    if (dv) begin
      case (m_pat)
        2'd0: c = BAR_TB[h / (HRES / 8)];
        2'd1: c = {3{8'(h)}};
        2'd2: c = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        default: c = {m_frames[7:0], 8'(h), 8'(v)};
      endcase
    end
    return {11'(h), 11'(v), dv, hs, vs, c, (m_pos == 0), m_frames, 1'b1};
  endfunction

  task automatic do_reset();
    rst = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; pattern_sel = 2'd0;
    #3;
    total++; if (obs !== 67'd0) begin bad++; $display("FAIL reset_value got=%h want=%h", obs, 67'd0); end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (obs !== 67'd0) begin bad++; $display("FAIL idle_hold got=%h want=%h", obs, 67'd0); end
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL idle_model got=%h want=%h", obs, exp_vec()); end
  endtask

  task automatic test_basic_frame();
    int dv_cnt = 0;
    bit idle_seen = 0;
    do_reset();
    pattern_sel = 2'd0; en = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL basic_model k=%0d got=%h want=%h", k, obs, exp_vec()); end
      if (k == 0) begin
        total++;
        if (!(frame_start === 1'b1 && busy === 1'b1 && h_cnt === 11'd0 && v_cnt === 11'd0)) begin
          bad++; $display("FAIL basic_first fs=%b busy=%b h=%0d v=%0d want fs=1 busy=1 h=0 v=0", frame_start, busy, h_cnt, v_cnt);
        end
      end
      if (k < FRAME) begin
        if (vga_dv_o === 1'b1) dv_cnt++;
        total++;
        if (vga_hs_o !== ((k % HTOT) >= 18 && (k % HTOT) <= 20)) begin
          bad++; $display("FAIL basic_hs k=%0d got=%b", k, vga_hs_o);
        end
        total++;
        if (vga_vs_o !== ((k / HTOT) >= 5 && (k / HTOT) <= 6)) begin
          bad++; $display("FAIL basic_vs k=%0d got=%b", k, vga_vs_o);
        end
      end
      if (k == 2) begin
        total++; if ({red, green, blue} !== 24'hFFFF00) begin bad++; $display("FAIL basic_bar_h2 got=%h want=FFFF00", {red, green, blue}); end
      end
      if (k == 15) begin
        total++; if ({red, green, blue} !== 24'h000000) begin bad++; $display("FAIL basic_bar_h15 got=%h want=000000", {red, green, blue}); end
      end
      if (k == FRAME) begin
        total++;
        if (!(frame_cnt === 16'd1 && frame_start === 1'b1)) begin
          bad++; $display("FAIL basic_frame_cnt got=%0d fs=%b want=1 fs=1", frame_cnt, frame_start);
        end
      end
    end
    total++; if (dv_cnt != 64) begin bad++; $display("FAIL basic_dv_count got=%0d want=64", dv_cnt); end
    en = 1'b0;
    for (int c = 0; c < 2 * FRAME && !idle_seen; c++) begin
      @(negedge clk);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL basic_tail c=%0d got=%h want=%h", c, obs, exp_vec()); end
      if (busy === 1'b0) idle_seen = 1;
    end
    total++; if (!idle_seen) begin bad++; $display("FAIL basic_idle_timeout busy=%b want=0", busy); end
  endtask

  task automatic test_drain();
    int idle_k = -1;
    int last_h = -1, last_v = -1;
    do_reset();
    pattern_sel = 2'd1; en = 1'b1;
    for (int k = 0; k < 2 * FRAME && idle_k < 0; k++) begin
      @(negedge clk);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL drain_model k=%0d got=%h want=%h", k, obs, exp_vec()); end
      if (k == HTOT + 5) en = 1'b0;
      if (busy === 1'b1) begin last_h = int'(h_cnt); last_v = int'(v_cnt); end
      else idle_k = k;
    end
    total++; if (idle_k != FRAME) begin bad++; $display("FAIL drain_idle_cycle got=%0d want=%0d", idle_k, FRAME); end
    total++; if (last_h != 23 || last_v != 7) begin bad++; $display("FAIL drain_last_pixel got=(%0d,%0d) want=(23,7)", last_h, last_v); end
    total++;
    if (obs !== {22'd0, 3'b000, 24'd0, 1'b0, 16'd1, 1'b0}) begin
      bad++; $display("FAIL drain_idle_outputs got=%h want=%h", obs, {22'd0, 3'b000, 24'd0, 1'b0, 16'd1, 1'b0});
    end
  endtask

  task automatic test_reenable();
    do_reset();
    pattern_sel = 2'd1; en = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL reen_model k=%0d got=%h want=%h", k, obs, exp_vec()); end
      total++;
      if (h_cnt !== 11'(k % HTOT) || v_cnt !== 11'((k / HTOT) % VTOT)) begin
        bad++; $display("FAIL reen_continuity k=%0d got=(%0d,%0d) want=(%0d,%0d)", k, h_cnt, v_cnt, k % HTOT, (k / HTOT) % VTOT);
      end
      if (k == 40) en = 1'b0;
      if (k == 50) en = 1'b1;
      if (k == FRAME) begin
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL reen_frame_start got=%b want=1", frame_start); end
      end
    end
  endtask

  task automatic test_pattern_latch();
    do_reset();
    pattern_sel = 2'd2; en = 1'b1;
    for (int k = 0; k <= FRAME + HTOT + 3; k++) begin
      @(negedge clk);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL latch_model k=%0d got=%h want=%h", k, obs, exp_vec()); end
      if (k < FRAME && (k % HTOT) < HRES && (k / HTOT) < VRES) begin
        total++; if ({red, green, blue} !== 24'h000000) begin bad++; $display("FAIL latch_checker k=%0d got=%h want=000000", k, {red, green, blue}); end
      end
      if (k == 2 * HTOT + 7) pattern_sel = 2'd3;
      if (k == FRAME + HTOT + 3) begin
        total++; if ({red, green, blue} !== 24'h010301) begin bad++; $display("FAIL latch_stamp got=%h want=010301", {red, green, blue}); end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    pattern_sel = 2'd3; en = 1'b1;
    for (int k = 0; k <= 2 * HTOT + 9; k++) begin
      @(negedge clk);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL mrst_model k=%0d got=%h want=%h", k, obs, exp_vec()); end
    end
    rst = 1'b0;
    #1;
    total++; if (obs !== 67'd0) begin bad++; $display("FAIL mrst_async got=%h want=%h", obs, 67'd0); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (!(h_cnt === 11'd0 && v_cnt === 11'd0 && busy === 1'b1 && frame_start === 1'b1 && frame_cnt === 16'd0)) begin
      bad++; $display("FAIL mrst_restart h=%0d v=%0d busy=%b fs=%b fc=%0d want 0,0,1,1,0", h_cnt, v_cnt, busy, frame_start, frame_cnt);
    end
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL mrst_restart_model got=%h want=%h", obs, exp_vec()); end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1; pattern_sel = 2'($urandom_range(0, 3));
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL rand_model c=%0d got=%h want=%h", c, obs, exp_vec()); end
      if ($urandom_range(0, 29) == 0) en = ~en;
      pattern_sel = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_drain();
    test_reenable();
    test_pattern_latch();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_pattern_tx.md
VIDEO_PATTERN_TX -- requirements
Module: video_pattern_tx

Interface
REQ-001 Parameter HRES, default 1600: active pixels per line.
REQ-002 Parameter VRES, default 900: active lines per frame.
REQ-003 Parameters H_FP/H_SYNC/H_BP, defaults 24/80/96: horizontal front porch, sync width and back porch, in clocks.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 1/3/96: vertical front porch, sync width and back porch, in lines.
REQ-005 Parameters HS_POL/VS_POL, default 1: sync active level.
REQ-006 clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  run request; level-sensitive.
REQ-009 pattern_sel  in  2  pattern select; sampled only at frame start.
REQ-010 h_cnt / v_cnt  out  11 each  coordinate of the pixel presented this cycle.
REQ-011 vga_dv_o / vga_hs_o / vga_vs_o  out  1 each  data valid, hsync and vsync.
REQ-012 red / green / blue  out  8 each  pixel data; 0 when vga_dv_o=0.
REQ-013 frame_start  out  1  one-cycle pulse coincident with pixel (0,0).
REQ-014 frame_cnt  out  16  completed-frame count; wraps at 0xFFFF->0.
REQ-015 busy  out  1  high in RUN and DRAIN.

Function
REQ-016 HTOT = HRES+H_FP+H_SYNC+H_BP; VTOT = VRES+V_FP+V_SYNC+V_BP.
- Horizontal order per line: active, front porch, sync, back porch.
- Vertical order per frame: the same sequence in lines.
REQ-017 h_cnt counts 0..HTOT-1 and wraps to 0; v_cnt increments when h_cnt wraps; v_cnt wraps 0..VTOT-1.
REQ-018 Output decode:
- vga_dv_o = (h_cnt<HRES) && (v_cnt<VRES).
- vga_hs_o = HS_POL while h_cnt is in [HRES+H_FP, HRES+H_FP+H_SYNC); otherwise it is the inverse level.
- vga_vs_o = VS_POL over the entire lines in [VRES+V_FP, VRES+V_FP+V_SYNC); otherwise it is the inverse level.
REQ-019 All outputs are registered and mutually aligned: within one cycle, h_cnt/v_cnt, dv/hs/vs and rgb all describe the same pixel.
REQ-020 FSM states IDLE, RUN, DRAIN:
- IDLE->RUN when en=1; the first RUN cycle presents pixel (0,0).
- RUN->DRAIN when en=0.
- DRAIN->RUN when en=1, with no counter restart.
- DRAIN->IDLE after pixel (HTOT-1, VTOT-1) is presented.
- RUN continues frame after frame.
REQ-021 In IDLE, outputs hold at: h_cnt=v_cnt=0, dv=0, hs/vs at their inactive levels, rgb=0, frame_start=0.
REQ-022 pattern_sel is latched on the cycle that presents (0,0), and that value holds for the whole frame.
REQ-023 Pattern 0 (colour bars): bar = h_cnt/(HRES/8).
- Bar colours 0..7: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- HRES SHALL be a multiple of 8.
REQ-024 Pattern 1 (ramp): red=green=blue=h_cnt[7:0].
REQ-025 Pattern 2 (checker): all channels FF when h_cnt[5]^v_cnt[5]=1, else 00.
REQ-026 Pattern 3 (coordinate stamp): red=frame_cnt[7:0], green=h_cnt[7:0], blue=v_cnt[7:0].
REQ-027 frame_cnt increments on the cycle after pixel (HTOT-1, VTOT-1) is presented, in both RUN and DRAIN.
REQ-028 en toggling mid-frame SHALL NOT alter the timing of the current frame.

Reset
REQ-029 While rst=0, the block is asynchronously forced to:
- state IDLE, counters 0, frame_cnt 0;
- dv=0, hs/vs inactive, rgb 0, frame_start 0, busy 0;
- latched pattern 0.
REQ-030 Reset asserted mid-frame aborts the frame immediately; after release, the block waits in IDLE for en.

Structure
REQ-031 Package video_pkg holds:
- the state enum;
- the pattern enum (BARS, RAMP, CHECKER, STAMP);
- the 8-entry bar colour table;
- a function computing HTOT/VTOT.
REQ-032 Sub-module video_timing_gen contains the h/v counters and the sync/dv decode, with a synchronous clear and an advance enable. video_pattern_tx contains the FSM, pattern generation and output registers.

Verification
REQ-033 Test parameters: HRES=16, VRES=4, H_FP=2, H_SYNC=3, H_BP=3, V_FP=1, V_SYNC=2, V_BP=1 (HTOT=24, VTOT=8).
REQ-034 Basic frame: reset, then en=1 with pattern 0.
- frame_start on the first busy cycle at (0,0).
- dv is high for 16 cycles per line on lines 0..3.
- hs is active for h_cnt 18..20.
- vs is active for v_cnt 5..6.
- Pixel h=2 is FFFF00; pixel h=15 is 000000.
- frame_cnt=1 after 192 cycles.
REQ-035 Drain: pattern 1, en dropped at (5,1).
- The frame completes through (23,7).
- busy falls and the state is IDLE on the next cycle.
- frame_cnt=1, and the outputs match REQ-021.
REQ-036 Re-enable in DRAIN: en 1->0->1 within frame 0.
- No counter discontinuity occurs.
- frame_start occurs again at cycle 192.
REQ-037 Pattern latch: pattern_sel changes 2->3 at (7,2).
- Frame 0 stays checker to its end.
- Frame 1 pixel (3,1) is red=01, green=03, blue=01.
REQ-038 Mid-frame reset: rst=0 at (9,2).
- Outputs go to reset values in the same cycle, without waiting for a clock edge.
- After release with en=1, (0,0) is the first pixel and frame_cnt=0.
